jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//   Shares one bank of WIDTH JK flip-flops between N_REQ requesters.
//   - Round-robin arbiter grants one requester per cycle.
//   - The winner's 2-bit command is decoded into per-bit J/K values and
//     applied to the masked bits of the bank.
//   - Sits between control agents and the JK storage bank; it is the only
//     writer of the bank state q/qbar.
// PARAMETERS
//   WIDTH   4   number of JK flip-flops in the bank
//   N_REQ   4   number of requesters (>=2)
// PORTS
//   clk    in   1            rising-edge clock
//   rst    in   1            synchronous reset, active-high
//   req    in   N_REQ        request per requester; held until its gnt bit is seen
//   cmd    in   2*N_REQ      cmd[2i+1:2i] for requester i: 00 hold, 01 reset, 10 set, 11 toggle
//   mask   in   WIDTH*N_REQ  mask[WIDTH*i +: WIDTH] selects the bits requester i acts on
//   clr    in   1            synchronous clear of the whole bank
//   gnt    out  N_REQ        registered one-hot grant pulse (1 cycle)
//   q      out  WIDTH        bank state
//   qbar   out  WIDTH        always ~q
//   busy   out  1            combinational |req
// BEHAVIOUR
//   Reset: gnt=0, q=0, qbar=all 1s, rr pointer=0 (requester 0 highest priority).
//   Priority per edge: rst > clr > grant > idle.
//   Arbitration:
//     - At each edge, sample req and pick the first set bit searching ptr, ptr+1, ..., wrapping mod N_REQ.
//     - Winner w: gnt becomes one-hot(w) after the edge; ptr <= (w+1) mod N_REQ.
//     - The JK update of w's command happens at the same edge, so q shows the result in the cycle gnt[w] is high.
//   Latency: 1 cycle from sampled req to gnt/q update. Throughput: 1 command per cycle.
//   Handshake:
//     - The requester drops req, or changes cmd/mask, in the cycle it sees gnt.
//     - A req still high at the next edge is a new request, arbitrated normally.
//       It is not favoured, because ptr has moved past it.
//   JK update: for each bit b with mask_w[b]=1, take j,k from cmd_w:
//     - hold = 0,0; reset = 0,1; set = 1,0; toggle = 1,1.
//     - q[b] <= (j & ~q[b]) | (~k & q[b]).
//     - Bits with mask_w[b]=0 hold.
//     - mask_w = 0 or cmd = hold: q is unchanged, but gnt still pulses and ptr still advances.
//   Idle (req = 0): gnt <= 0; ptr and q unchanged.
//   clr = 1: q <= 0; gnt <= 0; ptr unchanged. Pending reqs stay pending and are arbitrated on the next non-clr edge.
//   rst mid-operation: every state returns to its reset value at that edge. No grant is issued for requests present at that edge.
//   gnt is never more than one-hot. cmd/mask of non-winners are ignored.
// CONFIGURATION
//   JK_BANK_LOCK_EN defined:
//     - Adds input port "lock" (N_REQ bits).
//     - If the previous winner w had lock[w]=1 in its gnt cycle and req[w]=1 at the next edge, w wins again regardless of ptr.
//     - ptr is not advanced while locked.
//     - clr and rst drop the lock.
//   JK_BANK_LOCK_EN undefined: no lock port; pure round-robin as above.
// TESTING (WIDTH=4, N_REQ=4)
//   1. Assert rst 2 cycles -> q=0000, qbar=1111, gnt=0000, busy follows req.
//   2. From reset, req=0001, cmd0=set, mask0=0101 -> next cycle gnt=0001, q=0101.
//      Then req=0010, cmd1=toggle, mask1=1111 -> gnt=0010, q=1010, qbar=0101.
//   3. req=1111 held, all cmd=hold -> gnt sequence 0001,0010,0100,1000,0001 (wrap); q unchanged.
//   4. req=0100 with clr=1 in the same cycle -> q=0000, gnt=0000.
//      Next cycle (clr=0) -> gnt=0100 and cmd2 applied.
//   5. From q=0000, req0 toggle, mask=0011, on two consecutive grants -> q=0011 then 0000.
//      mask=0000 -> gnt pulses, q unchanged.
//   6. JK_BANK_LOCK_EN: req=0011, lock=0001 for 3 grants -> gnt 0001 x3.
//      Drop lock -> next gnt=0010.
//      rst mid-sequence -> gnt=0000, q=0000, ptr=0.

Source files
------------

// File: rtl/jk_bank_if.sv
// jk_bank_if
//   Bundles the request/command/status signals between the control agents
//   and jk_bank_arbiter.
//
//   Optional feature macro: JK_BANK_LOCK_EN. When it is defined, the
//   per-requester "lock" signal is added to the bundle and to both modports.
//
//   Signals
//     req   N_REQ        request per requester; held until its gnt bit is seen
//     cmd   2*N_REQ      cmd[2i+1:2i]: 00 hold, 01 reset, 10 set, 11 toggle
//     mask  WIDTH*N_REQ  mask[WIDTH*i +: WIDTH] selects the bits requester i acts on
//     clr   1            synchronous clear of the whole bank
//     lock  N_REQ        (JK_BANK_LOCK_EN only) keep the grant on the same requester
//     gnt   N_REQ        registered one-hot grant pulse
//     q     WIDTH        bank state
//     qbar  WIDTH        always ~q
//     busy  1            combinational |req
//
//   Modports
//     master  the control agents (drive requests, observe grant/state)
//     slave   the arbiter (observe requests, drive grant/state)
interface jk_bank_if #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     cmd;
  logic [WIDTH*N_REQ-1:0] mask;
  logic                   clr;
`ifdef JK_BANK_LOCK_EN
  logic [N_REQ-1:0]       lock;
`endif
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qbar;
  logic                   busy;

`ifdef JK_BANK_LOCK_EN
  modport master (
    output req, cmd, mask, clr, lock,
    input  gnt, q, qbar, busy
  );

  modport slave (
    input  req, cmd, mask, clr, lock,
    output gnt, q, qbar, busy
  );
`else
  modport master (
    output req, cmd, mask, clr,
    input  gnt, q, qbar, busy
  );

  modport slave (
    input  req, cmd, mask, clr,
    output gnt, q, qbar, busy
  );
`endif
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//   Shares one bank of WIDTH JK flip-flops between N_REQ requesters. A
//   round-robin arbiter picks one requester per clock edge; the winner's
//   2-bit command is decoded into per-bit J/K values and applied to the bits
//   selected by its mask. This block is the only writer of q/qbar.
//
//   Optional feature macro: JK_BANK_LOCK_EN. When defined, a requester that
//   holds lock high during its grant cycle and still requests at the next
//   edge wins again, without the round-robin pointer moving. clr and rst
//   drop the lock.
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   synchronous reset, active-high
//     bus   jk_bank_if.slave: req/cmd/mask/clr[/lock] in, gnt/q/qbar/busy out
//
//   Timing: 1 cycle from sampled req to gnt/q update, one command per cycle.
//   Edge priority: rst > clr > grant > idle.
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input  logic     clk,
  input  logic     rst,
  jk_bank_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef logic [PTR_W-1:0] idx_t;

  // First set request bit searching from p upwards with wrap-around.
  // Returns 1 when any request is present; w holds the winner index.
  function automatic logic rr_pick(input  logic [N_REQ-1:0] r,
                                   input  idx_t             p,
                                   output idx_t             w);
    logic hit;
    idx_t cand;
    int   pos;
    hit = 1'b0;
    w   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(p) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      cand = idx_t'(pos);
      if (!hit && r[cand]) begin
        hit = 1'b1;
        w   = cand;
      end
    end
    return hit;
  endfunction

  // Pointer value one past the winner, modulo N_REQ (N_REQ need not be a
  // power of two, so the wrap is explicit).
  function automatic idx_t ptr_after(input idx_t w);
    if (int'(w) == N_REQ - 1) return '0;
    return w + idx_t'(1);
  endfunction

  // JK next state for the masked bits: j = cmd[1], k = cmd[0].
  // hold 00, reset 01, set 10, toggle 11; unmasked bits see j = k = 0.
  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] qv,
                                                input logic [1:0]       c,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    j = m & {WIDTH{c[1]}};
    k = m & {WIDTH{c[0]}};
    return (j & ~qv) | (~k & qv);
  endfunction

  // Registered state (visible in the cycle after the deciding edge).
  logic [N_REQ-1:0] gnt_p1;
  logic [WIDTH-1:0] q_p1;
  idx_t             ptr_p1;
  idx_t             win_p1;
  logic             vld_p1;

  // Decision signals for the coming edge.
  logic             rr_hit_p0;
  idx_t             rr_win_p0;
  logic             relock_p0;
  logic             vld_p0;
  idx_t             win_p0;
  logic [1:0]       cmd_p0;
  logic [WIDTH-1:0] mask_p0;
  logic [WIDTH-1:0] q_nxt_p0;
  logic [N_REQ-1:0] gnt_nxt_p0;
  idx_t             ptr_nxt_p0;

  // A grant is outstanding exactly when gnt is non-zero; clr/rst zero gnt,
  // which is also what drops any lock.
  assign vld_p1 = |gnt_p1;

`ifdef JK_BANK_LOCK_EN
  assign relock_p0 = vld_p1 && bus.lock[win_p1] && bus.req[win_p1];
`else
  assign relock_p0 = 1'b0;
`endif

  // ---- stage p0: arbitration, command select, JK decode ----
  always_comb begin
    rr_win_p0  = '0;
    rr_hit_p0  = rr_pick(bus.req, ptr_p1, rr_win_p0);
    vld_p0     = rr_hit_p0;
    win_p0     = rr_win_p0;
    ptr_nxt_p0 = ptr_after(rr_win_p0);
    if (relock_p0) begin
      vld_p0     = 1'b1;
      win_p0     = win_p1;
      ptr_nxt_p0 = ptr_p1;
    end

    // cmd/mask of non-winners never reach the bank.
    cmd_p0  = '0;
    mask_p0 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_p0 == idx_t'(i)) begin
        cmd_p0  = bus.cmd[2*i +: 2];
        mask_p0 = bus.mask[WIDTH*i +: WIDTH];
      end
    end

    q_nxt_p0   = jk_apply(q_p1, cmd_p0, mask_p0);
    gnt_nxt_p0 = {{(N_REQ-1){1'b0}}, 1'b1} << win_p0;
  end

  // ---- stage p1: bank, grant and pointer registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_p1 <= '0;
      q_p1   <= '0;
      ptr_p1 <= '0;
      win_p1 <= '0;
    end else if (bus.clr) begin
      // Pending requests are left alone and compete at the next edge.
      gnt_p1 <= '0;
      q_p1   <= '0;
    end else if (vld_p0) begin
      gnt_p1 <= gnt_nxt_p0;
      q_p1   <= q_nxt_p0;
      ptr_p1 <= ptr_nxt_p0;
      win_p1 <= win_p0;
    end else begin
      gnt_p1 <= '0;
    end
  end

  assign bus.gnt  = gnt_p1;
  assign bus.q    = q_p1;
  assign bus.qbar = ~q_p1;
  assign bus.busy = |bus.req;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter
//   Directed bench for jk_bank_arbiter with WIDTH=4, N_REQ=4. Inputs change
//   1 time unit after each rising edge; outputs are sampled at the same point.
//   Lock scenarios are compiled only when JK_BANK_LOCK_EN is defined.
module tb_jk_bank_arbiter;

  localparam int WIDTH = 4;
  localparam int N_REQ = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jk_bank_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  jk_bank_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.cmd = '0; bus.mask = '0; bus.clr = 1'b0;
    step();
    step();
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL reset_q got=%b exp=0000", bus.q); end
    checks++; if (bus.qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar got=%b exp=1111", bus.qbar); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    bus.req = 4'b0101;
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy1 got=%b exp=1", bus.busy); end
    step();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_nogrant got=%b exp=0000", bus.gnt); end
    bus.req = '0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", bus.busy); end
    rst = 1'b0;
  endtask

  task automatic test_grant_basic();
    bus.req = 4'b0001; bus.cmd = 8'b00_00_00_10; bus.mask = 16'h0005;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt0 got=%b exp=0001", bus.gnt); end
    checks++; if (bus.q !== 4'b0101) begin errors++; $display("FAIL basic_q0 got=%b exp=0101", bus.q); end
    bus.req = 4'b0010; bus.cmd = 8'b00_00_11_00; bus.mask = 16'h00F0;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL basic_gnt1 got=%b exp=0010", bus.gnt); end
    checks++; if (bus.q !== 4'b1010) begin errors++; $display("FAIL basic_q1 got=%b exp=1010", bus.q); end
    checks++; if (bus.qbar !== 4'b0101) begin errors++; $display("FAIL basic_qbar1 got=%b exp=0101", bus.qbar); end
    bus.req = '0;
    step();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.q !== 4'b1010) begin errors++; $display("FAIL idle_q got=%b exp=1010", bus.q); end
  endtask

  // Pointer is 2 on entry; a lone req3 moves it to 0 before the full sweep.
  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    bus.req = 4'b1000; bus.cmd = '0; bus.mask = 16'hFFFF;
    step();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL rr_pre got=%b exp=1000", bus.gnt); end
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.gnt !== exp_gnt[i]) begin errors++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, bus.gnt, exp_gnt[i]); end
      checks++; if (bus.q !== 4'b1010) begin errors++; $display("FAIL rr_q%0d got=%b exp=1010", i, bus.q); end
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_clr();
    bus.req = 4'b0100; bus.cmd = 8'b00_10_00_00; bus.mask = 16'h0300; bus.clr = 1'b1;
    step();
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL clr_q got=%b exp=0000", bus.q); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL clr_gnt got=%b exp=0000", bus.gnt); end
    bus.clr = 1'b0;
    step();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL clr_after_gnt got=%b exp=0100", bus.gnt); end
    checks++; if (bus.q !== 4'b0011) begin errors++; $display("FAIL clr_after_q got=%b exp=0011", bus.q); end
    bus.req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL b2b_start_q got=%b exp=0000", bus.q); end
    bus.req = 4'b0001; bus.cmd = 8'b00_00_00_11; bus.mask = 16'h0003;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt0 got=%b exp=0001", bus.gnt); end
    checks++; if (bus.q !== 4'b0011) begin errors++; $display("FAIL b2b_q0 got=%b exp=0011", bus.q); end
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt1 got=%b exp=0001", bus.gnt); end
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL b2b_q1 got=%b exp=0000", bus.q); end
    step();
    checks++; if (bus.q !== 4'b0011) begin errors++; $display("FAIL b2b_q2 got=%b exp=0011", bus.q); end
    // Zero mask for the winner; requester 1 carries set/1111 but is not requesting.
    bus.cmd = 8'b00_00_10_11; bus.mask = 16'h00F0;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mask0_gnt got=%b exp=0001", bus.gnt); end
    checks++; if (bus.q !== 4'b0011) begin errors++; $display("FAIL mask0_q got=%b exp=0011", bus.q); end
    bus.req = '0;
    step();
  endtask

  // Pointer is 1 on entry; after rst, req=1001 must go to requester 0.
  task automatic test_rst_mid();
    bus.req = 4'b1111; bus.cmd = 8'hFF; bus.mask = 16'hFFFF; rst = 1'b1;
    step();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL rstmid_q got=%b exp=0000", bus.q); end
    checks++; if (bus.qbar !== 4'b1111) begin errors++; $display("FAIL rstmid_qbar got=%b exp=1111", bus.qbar); end
    rst = 1'b0; bus.req = 4'b1001; bus.cmd = '0;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got=%b exp=0001", bus.gnt); end
    bus.req = '0;
    step();
  endtask

`ifdef JK_BANK_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b0001; exp_q[1] = 4'b0000; exp_q[2] = 4'b0001;
    rst = 1'b1; bus.lock = '0; bus.req = '0;
    step();
    rst = 1'b0;
    bus.req = 4'b0011; bus.lock = 4'b0001; bus.cmd = 8'b00_00_00_11; bus.mask = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL lock_gnt%0d got=%b exp=0001", i, bus.gnt); end
      checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL lock_q%0d got=%b exp=%b", i, bus.q, exp_q[i]); end
    end
    bus.lock = '0;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL unlock_gnt got=%b exp=0010", bus.gnt); end
    bus.lock = 4'b0010;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL relock1_gnt got=%b exp=0010", bus.gnt); end
    rst = 1'b1;
    step();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL lock_rst_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL lock_rst_q got=%b exp=0000", bus.q); end
    rst = 1'b0; bus.lock = '0; bus.req = 4'b1001;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL lock_rst_ptr got=%b exp=0001", bus.gnt); end
    bus.req = '0;
    step();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = '0; bus.cmd = '0; bus.mask = '0; bus.clr = 1'b0;
`ifdef JK_BANK_LOCK_EN
    bus.lock = '0;
`endif
    test_reset();
    test_grant_basic();
    test_round_robin();
    test_clr();
    test_back_to_back();
    test_rst_mid();
`ifdef JK_BANK_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
